video_stream_switch: RTL and testbench



---
 rtl/vst_pkg.sv | 28 ++
 rtl/vst_out_reg.sv | 49 ++++
 rtl/video_stream_switch.sv | 151 +++++++++++++++
 tb/tb_video_stream_switch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vst_pkg.sv
// Shared types and constants for the video stream switch.
package vst_pkg;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;

  // SYNC: hunting for a control sop; IDLE: between packets; PKT: inside a packet.
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_PKT  = 2'd2
  } vst_state_e;

  // Frame tracking: a control packet opens a frame, a video packet closes it,
  // user packets leave it alone.
  function automatic logic frame_open_next(input logic cur, input logic [3:0] ptype);
    logic nxt;
    if (ptype == PKT_TYPE_CTRL) begin
      nxt = 1'b1;
    end else if (ptype == PKT_TYPE_VIDEO) begin
      nxt = 1'b0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vst_out_reg.sv
// Registered Avalon-ST output stage: valid/data/sop/eop with load and space logic.
module vst_out_reg #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic                  o_space
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_sop;
  logic                  r_eop;

  // The register can take a new beat when empty or when its beat leaves this cycle.
  assign o_space = !r_valid || i_ready;

  // Load a new beat, drop valid once consumed, otherwise hold everything stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;

endmodule

// File: rtl/video_stream_switch.sv
// Two-input Avalon-ST video source switch; changes source only at frame
// boundaries and resynchronises on the new source's next control packet.
module video_stream_switch
  import vst_pkg::*;
#(
  parameter int DATA_WIDTH      = 24,
  parameter bit DROP_UNSELECTED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  output logic                  sel_active,
  output logic                  discard,
  input  logic [DATA_WIDTH-1:0] din0_data,
  input  logic                  din0_startofpacket,
  input  logic                  din0_endofpacket,
  input  logic                  din0_valid,
  output logic                  din0_ready,
  input  logic [DATA_WIDTH-1:0] din1_data,
  input  logic                  din1_startofpacket,
  input  logic                  din1_endofpacket,
  input  logic                  din1_valid,
  output logic                  din1_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  vst_state_e r_state;
  logic       r_sel_active;
  logic       r_frame_open;
  logic       r_discard;
  logic [3:0] r_pkt_type;

  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_sop;
  logic                  w_sel_eop;
  logic                  w_sel_valid;
  logic                  w_space;
  logic                  w_switch;
  logic                  w_sel_ready;
  logic                  w_unsel_ready;
  logic                  w_xfer;
  logic                  w_fwd;
  logic                  w_drop;
  logic [3:0]            w_beat_type;
  logic [3:0]            w_pkt_type;

  // Route the currently forwarded source onto the internal beat wires.
  always_comb begin
    if (r_sel_active) begin
      w_sel_data  = din1_data;
      w_sel_sop   = din1_startofpacket;
      w_sel_eop   = din1_endofpacket;
      w_sel_valid = din1_valid;
    end else begin
      w_sel_data  = din0_data;
      w_sel_sop   = din0_startofpacket;
      w_sel_eop   = din0_endofpacket;
      w_sel_valid = din0_valid;
    end
  end

  assign w_beat_type = w_sel_data[3:0];

  // A switch cycle happens at once while hunting, or between packets when no frame is open.
  always_comb begin
    w_switch = 1'b0;
    if (!reset && (sel != r_sel_active)) begin
      case (r_state)
        ST_SYNC: w_switch = 1'b1;
        ST_IDLE: w_switch = !r_frame_open;
        ST_PKT:  w_switch = 1'b0;
        default: w_switch = 1'b0;
      endcase
    end else begin
      w_switch = 1'b0;
    end
  end

  // Both inputs are held off during reset and during the switch cycle.
  assign w_sel_ready   = !reset && !w_switch && w_space;
  assign w_unsel_ready = !reset && !w_switch && DROP_UNSELECTED;
  assign din0_ready    = r_sel_active ? w_unsel_ready : w_sel_ready;
  assign din1_ready    = r_sel_active ? w_sel_ready : w_unsel_ready;
  assign w_xfer        = w_sel_valid && w_sel_ready;

  // Decide whether an accepted beat from the selected input goes downstream.
  always_comb begin
    w_fwd = 1'b0;
    case (r_state)
      ST_SYNC: w_fwd = w_xfer && w_sel_sop && (w_beat_type == PKT_TYPE_CTRL);
      ST_IDLE: w_fwd = w_xfer && w_sel_sop;
      ST_PKT:  w_fwd = w_xfer;
      default: w_fwd = 1'b0;
    endcase
  end

  assign w_drop     = w_xfer && !w_fwd;
  // Inside a packet the type comes from its sop beat; otherwise from this beat.
  assign w_pkt_type = (r_state == ST_PKT) ? r_pkt_type : w_beat_type;

  vst_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_fwd),
    .i_data  (w_sel_data),
    .i_sop   (w_sel_sop),
    .i_eop   (w_sel_eop),
    .i_ready (dout_ready),
    .o_valid (dout_valid),
    .o_data  (dout_data),
    .o_sop   (dout_startofpacket),
    .o_eop   (dout_endofpacket),
    .o_space (w_space)
  );

  // Packet/frame state machine with source selection and discard pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_SYNC;
      r_sel_active <= 1'b0;
      r_frame_open <= 1'b0;
      r_pkt_type   <= 4'h0;
      r_discard    <= 1'b0;
    end else begin
      r_discard <= w_drop;
      if (w_switch) begin
        r_sel_active <= sel;
        r_state      <= ST_SYNC;
        r_frame_open <= 1'b0;
      end else if (w_fwd) begin
        r_pkt_type <= w_pkt_type;
        if (w_sel_eop) begin
          r_state      <= ST_IDLE;
          r_frame_open <= frame_open_next(r_frame_open, w_pkt_type);
        end else begin
          r_state <= ST_PKT;
        end
      end
    end
  end

  assign sel_active = r_sel_active;
  assign discard    = r_discard;

endmodule

// File: tb/tb_video_stream_switch.sv
// Randomised bench for video_stream_switch with a packet-level reference model.
module tb_video_stream_switch;

  localparam int DW = 24;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, sel, dout_ready;
  logic [DW-1:0] din0_data, din1_data;
  logic          din0_sop, din0_eop, din0_valid, din1_sop, din1_eop, din1_valid;
  logic          din0_ready, din1_ready, sel_active, discard;
  logic [DW-1:0] dout_data;
  logic          dout_sop, dout_eop, dout_valid;
  logic          n_din0_ready, n_din1_ready, n_sel_active, n_discard;
  logic [DW-1:0] n_dout_data;
  logic          n_dout_sop, n_dout_eop, n_dout_valid;

  video_stream_switch #(.DATA_WIDTH(DW), .DROP_UNSELECTED(1'b1)) dut (
    .clk(clk), .reset(reset), .sel(sel), .sel_active(sel_active), .discard(discard),
    .din0_data(din0_data), .din0_startofpacket(din0_sop), .din0_endofpacket(din0_eop),
    .din0_valid(din0_valid), .din0_ready(din0_ready),
    .din1_data(din1_data), .din1_startofpacket(din1_sop), .din1_endofpacket(din1_eop),
    .din1_valid(din1_valid), .din1_ready(din1_ready),
    .dout_data(dout_data), .dout_startofpacket(dout_sop), .dout_endofpacket(dout_eop),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  video_stream_switch #(.DATA_WIDTH(DW), .DROP_UNSELECTED(1'b0)) dut_nd (
    .clk(clk), .reset(reset), .sel(sel), .sel_active(n_sel_active), .discard(n_discard),
    .din0_data(din0_data), .din0_startofpacket(din0_sop), .din0_endofpacket(din0_eop),
    .din0_valid(din0_valid), .din0_ready(n_din0_ready),
    .din1_data(din1_data), .din1_startofpacket(din1_sop), .din1_endofpacket(din1_eop),
    .din1_valid(din1_valid), .din1_ready(n_din1_ready),
    .dout_data(n_dout_data), .dout_startofpacket(n_dout_sop), .dout_endofpacket(n_dout_eop),
    .dout_valid(n_dout_valid), .dout_ready(dout_ready)
  );

  int checks = 0;
  int failures = 0;
  int cnt_out = 0;
  int cnt_disc = 0;
  logic got_sop = 1'b0;
  logic [DW-1:0] first_sop = '0;
  logic xf0 = 1'b0, xf1 = 1'b0;
  int vprob = 100;
  int rseq = 100;
  beat_t q0[$];
  beat_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (packet-level rules) ----------------
  logic          m_valid = 1'b0, m_sop = 1'b0, m_eop = 1'b0, m_disc = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_src = 1'b0, m_hunt = 1'b1, m_inpkt = 1'b0, m_fopen = 1'b0;
  logic [3:0]    m_type = 4'h0;
  logic          p_valid, p_sop, p_eop, p_disc, p_src, p_hunt, p_inpkt, p_fopen;
  logic [DW-1:0] p_data;
  logic [3:0]    p_type, ty;
  logic          sv, ssop, seop, sw, rs, ru, acc, fwd;
  logic [DW-1:0] sd;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      #4;
      sv   = m_src ? din1_valid : din0_valid;
      sd   = m_src ? din1_data : din0_data;
      ssop = m_src ? din1_sop : din0_sop;
      seop = m_src ? din1_eop : din0_eop;
      sw   = !reset && (sel != m_src) && (m_hunt || (!m_inpkt && !m_fopen));
      rs   = !reset && !sw && (!m_valid || dout_ready);
      ru   = !reset && !sw;
      check("din0_ready", din0_ready, m_src ? ru : rs);
      check("din1_ready", din1_ready, m_src ? rs : ru);
      check("nd_din0_ready", n_din0_ready, m_src ? 1'b0 : rs);
      check("nd_din1_ready", n_din1_ready, m_src ? rs : 1'b0);
      xf0 = din0_valid && din0_ready;
      xf1 = din1_valid && din1_ready;
      if (dout_valid && dout_ready) begin
        cnt_out++;
        if (dout_sop && !got_sop) begin
          got_sop = 1'b1;
          first_sop = dout_data;
        end
      end
      if (discard) cnt_disc++;
      acc = sv && rs;
      fwd = acc && (m_inpkt || (ssop && (!m_hunt || sd[3:0] == 4'hF)));
      if (reset) begin
        {p_valid, p_sop, p_eop, p_disc, p_src, p_inpkt, p_fopen} = 7'b0;
        p_hunt = 1'b1; p_data = '0; p_type = 4'h0;
      end else begin
        {p_valid, p_data, p_sop, p_eop} = {m_valid, m_data, m_sop, m_eop};
        {p_src, p_hunt, p_inpkt, p_fopen, p_type} = {m_src, m_hunt, m_inpkt, m_fopen, m_type};
        p_disc = acc && !fwd;
        if (fwd) {p_valid, p_data, p_sop, p_eop} = {1'b1, sd, ssop, seop};
        else if (dout_ready) p_valid = 1'b0;
        if (sw) begin
          p_src = sel; p_hunt = 1'b1; p_inpkt = 1'b0; p_fopen = 1'b0;
        end else if (fwd) begin
          ty = m_inpkt ? m_type : sd[3:0];
          p_type = ty; p_hunt = 1'b0; p_inpkt = !seop;
          if (seop && ty == 4'hF) p_fopen = 1'b1;
          if (seop && ty == 4'h0) p_fopen = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      {m_valid, m_data, m_sop, m_eop, m_disc} = {p_valid, p_data, p_sop, p_eop, p_disc};
      {m_src, m_hunt, m_inpkt, m_fopen, m_type} = {p_src, p_hunt, p_inpkt, p_fopen, p_type};
      check("dout_valid", dout_valid, m_valid);
      if (m_valid) begin
        check("dout_data", dout_data, m_data);
        check("dout_sop", dout_sop, m_sop);
        check("dout_eop", dout_eop, m_eop);
      end
      check("sel_active", sel_active, m_src);
      check("discard", discard, m_disc);
      check("nd_dout_valid", n_dout_valid, m_valid);
      if (m_valid) check("nd_dout_data", n_dout_data, m_data);
      check("nd_sel_active", n_sel_active, m_src);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_pkt(input int src, input logic [3:0] ptype, input int len, input logic [18:0] sq);
    logic s;
    s = src[0];
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d   = {s, sq, (i == 0) ? ptype : 4'($urandom)};
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      if (s) q1.push_back(b); else q0.push_back(b);
    end
  endtask

  task automatic push_stray(input int src);
    beat_t b;
    b.d = {src[0], 19'h7FFFF, 4'h5};
    b.sop = 1'b0;
    b.eop = 1'b0;
    if (src[0]) q1.push_back(b); else q0.push_back(b);
  endtask

  task automatic push_random(input int src);
    int r;
    r = $urandom_range(99);
    rseq++;
    if (r < 10) push_stray(src);
    else if (r < 35) push_pkt(src, 4'hF, $urandom_range(4, 1), 19'(rseq));
    else if (r < 75) push_pkt(src, 4'h0, $urandom_range(24, 2), 19'(rseq));
    else push_pkt(src, 4'($urandom_range(14, 1)), $urandom_range(3, 1), 19'(rseq));
  endtask

  // Advance one cycle: retire transferred beats, present the next ones.
  task automatic step();
    @(negedge clk);
    if (xf0 && q0.size() > 0) q0.delete(0);
    if (xf1 && q1.size() > 0) q1.delete(0);
    if (q0.size() > 0 && $urandom_range(99) < vprob) begin
      din0_valid = 1'b1; din0_data = q0[0].d; din0_sop = q0[0].sop; din0_eop = q0[0].eop;
    end else begin
      din0_valid = 1'b0;
    end
    if (q1.size() > 0 && $urandom_range(99) < vprob) begin
      din1_valid = 1'b1; din1_data = q1[0].d; din1_sop = q1[0].sop; din1_eop = q1[0].eop;
    end else begin
      din1_valid = 1'b0;
    end
  endtask

  task automatic run_until(input int src, input int max);
    int n;
    n = 0;
    while ((src == 0 ? q0.size() : q1.size()) > 0 && n < max) begin
      step();
      n++;
    end
    check("drain_bound", src == 0 ? q0.size() : q1.size(), 0);
  endtask

  task automatic clear_counts();
    cnt_out = 0; cnt_disc = 0; got_sop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; dout_ready = 1'b1;
    din0_data = '0; din0_sop = 1'b0; din0_eop = 1'b0; din0_valid = 1'b0;
    din1_data = '0; din1_sop = 1'b0; din1_eop = 1'b0; din1_valid = 1'b0;
    repeat (3) step();
    #4;
    check("rst_din0_ready", din0_ready, 0);
    check("rst_din1_ready", din1_ready, 0);
    step();
    reset = 1'b0;
    #1;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_sel_active", sel_active, 0);
    check("rst_discard", discard, 0);

    // Control then video on din0, straight through.
    clear_counts();
    push_pkt(0, 4'hF, 4, 19'd0);
    push_pkt(0, 4'h0, 12, 19'd1);
    run_until(0, 100);
    repeat (3) step();
    check("p1_beats", cnt_out, 16);
    check("p1_discards", cnt_disc, 0);
    check("p1_first_sop", first_sop, 24'h00000F);

    // Request din1 mid-video: switch waits for the video eop.
    push_pkt(0, 4'h0, 10, 19'd2);
    repeat (4) step();
    check("p2_sel_hold", sel_active, 0);
    sel = 1'b1;
    run_until(0, 100);
    #1;
    check("p2_sel_at_idle", sel_active, 0);
    @(posedge clk);
    #1;
    check("p2_sel_switched", sel_active, 1);
    clear_counts();
    push_pkt(1, 4'h0, 5, 19'd5);
    push_pkt(1, 4'hF, 4, 19'd0);
    push_pkt(1, 4'h0, 6, 19'd6);
    run_until(1, 100);
    repeat (3) step();
    check("p2_discards", cnt_disc, 5);
    check("p2_beats", cnt_out, 10);
    check("p2_first_sop", first_sop, 24'h80000F);

    // Stray non-sop beat in IDLE is accepted and discarded.
    clear_counts();
    push_stray(1);
    run_until(1, 20);
    repeat (3) step();
    check("p3_discards", cnt_disc, 1);
    check("p3_beats", cnt_out, 0);

    // sel bounces away and back within one frame: no switch.
    clear_counts();
    push_pkt(1, 4'hF, 4, 19'd7);
    push_pkt(1, 4'h0, 10, 19'd8);
    repeat (6) step();
    sel = 1'b0;
    repeat (3) step();
    sel = 1'b1;
    run_until(1, 100);
    repeat (3) step();
    check("p4_beats", cnt_out, 14);
    check("p4_discards", cnt_disc, 0);
    check("p4_sel_active", sel_active, 1);

    // One-cycle reset mid-packet; resume only at the next control sop.
    push_pkt(1, 4'hF, 4, 19'd9);
    push_pkt(1, 4'h0, 10, 19'd10);
    repeat (8) step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("p5_dout_valid", dout_valid, 0);
    check("p5_sel_active", sel_active, 0);
    step();
    reset = 1'b0;
    clear_counts();
    push_pkt(1, 4'hF, 2, 19'd0);
    run_until(1, 100);
    repeat (3) step();
    check("p5_first_sop", first_sop, 24'h80000F);
    check("p5_beats", cnt_out, 2);

    // Randomised traffic, back-pressure, source changes and resets.
    vprob = 75;
    for (int c = 0; c < 4000; c++) begin
      step();
      dout_ready = 1'($urandom_range(1));
      if ($urandom_range(59) == 0) sel = ~sel;
      reset = ($urandom_range(1499) == 0);
      if (q0.size() == 0) push_random(0);
      if (q1.size() == 0) push_random(1);
    end
    reset = 1'b0;
    dout_ready = 1'b1;
    repeat (50) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
